// File: rtl/lane_accum_adder_if.sv
// Operand/result bundle for lane_accum_adder.
// master drives operands and controls, slave is the adder side.
interface lane_accum_adder_if #(
   parameter int DATA_W = 4,
   parameter int LANES  = 4,
   parameter int ACC_W  = 8
);
   logic                    C_EN;
   logic                    in_valid;
   logic                    mode;
   logic                    clear;
   logic [LANES*DATA_W-1:0] a;
   logic [LANES*DATA_W-1:0] b;
   logic [LANES*ACC_W-1:0]  sum;
   logic                    out_valid;
   logic [LANES-1:0]        ovf;
   logic                    busy;

   modport master (
      output C_EN, in_valid, mode, clear, a, b,
      input  sum, out_valid, ovf, busy
   );

   modport slave (
      input  C_EN, in_valid, mode, clear, a, b,
      output sum, out_valid, ovf, busy
   );
endinterface

// File: rtl/lane_accum_adder.sv
// Multi-lane unsigned adder with PAIR and ACCUM (ACC_LEN-beat) modes.
// Define LANE_ACC_SAT_EN to clamp overflowing lanes instead of wrapping.
module lane_accum_adder #(
   parameter int DATA_W  = 4,
   parameter int LANES   = 4,
   parameter int ACC_W   = 8,
   parameter int ACC_LEN = 4
) (
   input  logic               clk,
   input  logic               rst,
   lane_accum_adder_if.slave  bus
);
   localparam int CW = $clog2(ACC_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACC  = 1'b1;

   logic [0:0]             state;
   logic [CW-1:0]          cnt;
   logic [LANES*ACC_W-1:0] acc;
   logic [LANES*ACC_W-1:0] nxt;
   logic [LANES*ACC_W-1:0] sum_q;
   logic [LANES-1:0]       sticky;
   logic [LANES-1:0]       cy;
   logic [LANES-1:0]       ovf_n;
   logic [LANES-1:0]       ovf_q;
   logic                   out_valid_q;
   logic                   in_acc;

   assign in_acc = (state == ACC);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_W:0]  t;
      logic [ACC_W-1:0] base;
      logic [ACC_W:0]   wide;

      assign t = {1'b0, bus.a[i*DATA_W +: DATA_W]}
               + {1'b0, bus.b[i*DATA_W +: DATA_W]};
      assign base  = in_acc ? acc[i*ACC_W +: ACC_W] : '0;
      assign wide  = {1'b0, base} + (ACC_W+1)'(t);
      assign cy[i] = wide[ACC_W];
`ifdef LANE_ACC_SAT_EN
      // once a lane has overflowed it stays pinned at full scale
      assign nxt[i*ACC_W +: ACC_W] =
         (cy[i] | (in_acc & sticky[i])) ? '1 : wide[ACC_W-1:0];
`else
      assign nxt[i*ACC_W +: ACC_W] = wide[ACC_W-1:0];
`endif
   end

   assign ovf_n = (in_acc ? sticky : '0) | cy;

   logic go_clr, go_pair, go_start, go_end, go_add, beat;

   assign beat     = bus.C_EN & bus.in_valid & ~bus.clear;
   assign go_clr   = bus.C_EN & bus.clear;
   assign go_pair  = beat & ~in_acc & ~bus.mode;
   assign go_start = beat & ~in_acc & bus.mode;
   assign go_end   = beat & in_acc & (cnt == LAST);
   assign go_add   = beat & in_acc & (cnt != LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         sticky      <= '0;
         sum_q       <= '0;
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.C_EN) begin
         out_valid_q <= 1'b0;
         unique case (1'b1)
            go_clr: begin
               state  <= IDLE;
               cnt    <= '0;
               acc    <= '0;
               sticky <= '0;
            end
            go_pair: begin
               sum_q       <= nxt;
               ovf_q       <= ovf_n;
               out_valid_q <= 1'b1;
            end
            go_start: begin
               state  <= ACC;
               cnt    <= CW'(1);
               acc    <= nxt;
               sticky <= ovf_n;
            end
            go_end: begin
               state       <= IDLE;
               cnt         <= '0;
               acc         <= '0;
               sticky      <= '0;
               sum_q       <= nxt;
               ovf_q       <= ovf_n;
               out_valid_q <= 1'b1;
            end
            go_add: begin
               cnt    <= cnt + CW'(1);
               acc    <= nxt;
               sticky <= ovf_n;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum       = sum_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = in_acc;
endmodule

// File: tb/tb_lane_accum_adder.sv
// Directed bench for lane_accum_adder (ACC_W=8 main DUT, ACC_W=6 overflow DUT).
// Overflow expectations follow LANE_ACC_SAT_EN.
module tb_lane_accum_adder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic c_en, in_valid, mode, clear;
   logic [15:0] a, b;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lane_accum_adder_if #(.DATA_W(4), .LANES(4), .ACC_W(8)) u_if ();
   lane_accum_adder_if #(.DATA_W(4), .LANES(4), .ACC_W(6)) u_if6 ();

   assign u_if.C_EN      = c_en;
   assign u_if.in_valid  = in_valid;
   assign u_if.mode      = mode;
   assign u_if.clear     = clear;
   assign u_if.a         = a;
   assign u_if.b         = b;
   assign u_if6.C_EN     = c_en;
   assign u_if6.in_valid = in_valid;
   assign u_if6.mode     = mode;
   assign u_if6.clear    = clear;
   assign u_if6.a        = a;
   assign u_if6.b        = b;

   lane_accum_adder #(.DATA_W(4), .LANES(4), .ACC_W(8), .ACC_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   lane_accum_adder #(.DATA_W(4), .LANES(4), .ACC_W(6), .ACC_LEN(4)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (u_if6.slave)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [23:0] exp6;

   initial begin
`ifdef LANE_ACC_SAT_EN
      exp6 = {4{6'h3F}};
`else
      exp6 = {4{6'h38}};
`endif
      c_en = 1'b1;
      in_valid = 1'b1;
      mode = 1'($urandom);
      clear = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      a = 16'($urandom);
      tick();
      check("rst_sum", u_if.sum, 32'h0);
      check("rst_ov", {31'b0, u_if.out_valid}, 32'h0);
      check("rst_ovf", {28'b0, u_if.ovf}, 32'h0);
      check("rst_busy", {31'b0, u_if.busy}, 32'h0);

      in_valid = 1'b0;
      rst = 1'b1;
      tick();

      // PAIR
      mode = 1'b0;
      in_valid = 1'b1;
      a = 16'h006A;
      b = 16'h006F;
      tick();
      check("pair_sum", u_if.sum, 32'h00000C19);
      check("pair_ov", {31'b0, u_if.out_valid}, 32'h1);
      check("pair_ovf", {28'b0, u_if.ovf}, 32'h0);
      in_valid = 1'b0;
      tick();
      check("pair_ov_drop", {31'b0, u_if.out_valid}, 32'h0);
      check("pair_hold", u_if.sum, 32'h00000C19);

      // ACCUM, two back-to-back groups
      mode = 1'b1;
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      for (int g = 0; g < 2; g++) begin
         for (int k = 0; k < 3; k++) begin
            tick();
            check("acc_busy", {31'b0, u_if.busy}, 32'h1);
            check("acc_noov", {31'b0, u_if.out_valid}, 32'h0);
         end
         tick();
         check("acc_sum", u_if.sum, 32'h78787878);
         check("acc_ov", {31'b0, u_if.out_valid}, 32'h1);
         check("acc_idle", {31'b0, u_if.busy}, 32'h0);
         check("acc_ovf", {28'b0, u_if.ovf}, 32'h0);
         check("w6_sum", {8'b0, u_if6.sum}, {8'b0, exp6});
         check("w6_ovf", {28'b0, u_if6.ovf}, 32'hF);
      end

      // gaps and clock-enable stalls
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("gap_ov", {31'b0, u_if.out_valid}, 32'h0);
      in_valid = 1'b1;
      tick();
      c_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("cen_busy", {31'b0, u_if.busy}, 32'h1);
         check("cen_ov", {31'b0, u_if.out_valid}, 32'h0);
      end
      c_en = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("gap_ov2", {31'b0, u_if.out_valid}, 32'h0);
      in_valid = 1'b1;
      tick();
      check("gap_sum", u_if.sum, 32'h78787878);
      check("gap_ov3", {31'b0, u_if.out_valid}, 32'h1);
      in_valid = 1'b0;
      c_en = 1'b0;
      tick();
      check("cen_ov_hold", {31'b0, u_if.out_valid}, 32'h1);
      c_en = 1'b1;
      tick();
      check("cen_no_repulse", {31'b0, u_if.out_valid}, 32'h0);

      // clear mid-group with a colliding beat
      in_valid = 1'b1;
      a = 16'h2222;
      b = 16'h3333;
      tick();
      tick();
      clear = 1'b1;
      tick();
      check("clr_ov", {31'b0, u_if.out_valid}, 32'h0);
      check("clr_busy", {31'b0, u_if.busy}, 32'h0);
      check("clr_sum_hold", u_if.sum, 32'h78787878);
      clear = 1'b0;
      a = 16'h1111;
      b = 16'h1111;
      for (int k = 0; k < 4; k++) tick();
      check("clr_sum", u_if.sum, 32'h08080808);
      check("clr_ov2", {31'b0, u_if.out_valid}, 32'h1);

      // asynchronous reset mid-group
      tick();
      check("mid_busy", {31'b0, u_if.busy}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_sum", u_if.sum, 32'h0);
      check("arst_busy", {31'b0, u_if.busy}, 32'h0);
      check("arst_ovf6", {28'b0, u_if6.ovf}, 32'h0);
      check("arst_sum6", {8'b0, u_if6.sum}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lane_accum_adder.md
Name: lane_accum_adder

Overview:
- Parametrised multi-lane unsigned adder/accumulator for the convolution datapath; successor to the single-pair 4-bit adder.
- Adds LANES independent a/b operand pairs per beat.
- Two modes: PAIR returns the registered per-beat sum; ACCUM returns the sum of ACC_LEN beats per lane (partial-sum reduction for a kernel window).
- Sits between the multiplier array and the output buffer.

Parameters:
- DATA_W, 4, width of each a/b lane operand.
- LANES, 4, number of independent lanes.
- ACC_W, 8, width of each lane result/accumulator (ACC_W > DATA_W).
- ACC_LEN, 4, valid beats per ACCUM group (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- C_EN  input  1  clock enable; 0 freezes all state.
- in_valid  input  1  operand beat valid.
- mode  input  1  0 = PAIR, 1 = ACCUM; sampled on the first beat of a group.
- clear  input  1  synchronous abort/zero of the current group.
- a  input  LANES*DATA_W  lane operands A, lane0 in LSBs.
- b  input  LANES*DATA_W  lane operands B, lane0 in LSBs.
- sum  output  LANES*ACC_W  lane results, lane0 in LSBs.
- out_valid  output  1  one-cycle pulse: sum holds a new result.
- ovf  output  LANES  per-lane overflow flag for the current result.
- busy  output  1  high while an ACCUM group is partially collected.

Behaviour:
- Reset (rst=0, asynchronous): sum=0, out_valid=0, ovf=0, busy=0, accumulators=0, beat counter=0, state=IDLE. Release is synchronous to clk.
- Beat accepted when C_EN=1 and in_valid=1 at a rising edge.
- C_EN=0: all registers hold. out_valid keeps its value and does not re-pulse when C_EN returns.
- Arithmetic:
  - Unsigned. Lane term t = a_i + b_i (DATA_W+1 bits), zero-extended to ACC_W.
  - Results wrap modulo 2^ACC_W.
  - ovf_i=1 if any carry out of ACC_W occurred while forming that lane's result.
- States: IDLE, ACC.
- IDLE, accepted beat, mode=0 (PAIR):
  - Next edge: sum_i = t_i, ovf_i set, out_valid=1.
  - Stay IDLE. Latency 1; throughput 1 beat/cycle.
- IDLE, accepted beat, mode=1 (ACCUM):
  - acc_i = t_i, count=1, busy=1, go to ACC. No out_valid.
- ACC, accepted beat:
  - acc_i += t_i, count += 1. mode is ignored.
  - On the ACC_LEN-th beat, next edge: sum_i = final acc_i, ovf_i = sticky group overflow, out_valid=1, accumulators and count zeroed, busy=0, return to IDLE.
  - The next beat may arrive in the following cycle with no bubble.
- ACC, no beat: hold; out_valid=0.
- out_valid is 0 in every cycle not listed above. sum and ovf hold their last values until the next result.
- clear=1 with C_EN=1:
  - Accumulators, count, busy and sticky ovf are zeroed; state goes to IDLE; no out_valid.
  - A beat presented in the same cycle is discarded.
  - sum and ovf outputs keep their last result.
- clear has priority over in_valid. rst has priority over everything.
- Reset mid-group: the partial group is lost; outputs are zero.

Optional Feature:
- Macro: LANE_ACC_SAT_EN.
- Defined: on overflow the lane result clamps to 2^ACC_W-1 and stays clamped for the rest of the group; ovf_i is still reported.
- Undefined: wrap-around modulo 2^ACC_W as above.
- Port list is identical in both builds.

Test Plan:
- Reset: hold rst=0 with random inputs and C_EN=1 -> sum=0, out_valid=0, ovf=0, busy=0. Assert rst mid-ACCUM group -> all outputs 0 immediately, without waiting for a clock edge.
- PAIR, defaults: lane0 a=4'b1010, b=4'b1111; lane1 a=4'b0110, b=4'b0110 -> one cycle later sum lane0=8'h19, lane1=8'h0C, out_valid single pulse, ovf=0.
- ACCUM, ACC_LEN=4: all lanes a=b=4'hF for 4 consecutive beats -> busy=1 during beats 1-3; after beat 4 all lanes = 8'h78 with a one-cycle out_valid; back-to-back group starts the next cycle.
- Gaps and C_EN: ACCUM with in_valid low between beats and C_EN=0 for 3 cycles mid-group -> same 8'h78 result; no extra pulses.
- Overflow, ACC_W=6: same 4 beats of 30 -> wrap build gives 6'h38 with ovf=all-ones; LANE_ACC_SAT_EN build gives 6'h3F with ovf=all-ones.
- clear: assert clear after beat 2 of a group, together with a valid beat -> no out_valid, busy=0. The following 4-beat group of a=1, b=1 yields 8'h08 per lane.
